adder_accum: RTL and testbench
==============================

# adder_accum

Frame accumulator placed directly upstream and downstream of the 6-bit prefix `adder`. It accepts a stream of 6-bit samples through a valid/ready handshake. Each sample is added to a registered running sum by one instance of `adder`: the sum is driven on X, the sample on Y. The adder's `cout` extends the result through an upper carry counter. After NSAMP samples it presents the wide frame sum and an overflow flag on an output handshake, then clears itself for the next frame.

## Interface
Parameters:
- NSAMP, default 8: samples per frame; legal range 1..255.
- HW, default 4: width of the upper carry counter; total result width is 6+HW.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: the sample on in_data is valid.
- in_ready, output, 1: the block can accept a sample this cycle.
- in_data, input, 6: unsigned sample.
- out_valid, output, 1: out_sum and out_ovf hold a completed frame.
- out_ready, input, 1: the consumer accepts the frame.
- out_sum, output, 6+HW: frame sum; bits [5:0] are the adder-side low word, bits [5+HW:6] are the carry counter.
- out_ovf, output, 1: sticky flag; set if the carry counter wrapped during the frame.

## Operation
- Internal registers:
  - acc_lo[5:0]
  - acc_hi[HW-1:0]
  - ovf
  - cnt[7:0]
  - state ∈ {ACC, HOLD}
- Datapath: one `adder` instance with X=acc_lo, Y=in_data. S and cout feed the next-state logic only. No second adder is used for the low word.
- An accept occurs when in_valid && in_ready. On accept:
  - acc_lo <= S.
  - If cout=1, then acc_hi <= acc_hi+1, wrapping modulo 2^HW.
  - If cout=1 and acc_hi is all ones, ovf <= 1. Once set, ovf stays 1 until the frame is cleared.
  - cnt <= cnt+1.
- State ACC:
  - in_ready=1 and out_valid=0.
  - An accept with cnt==NSAMP-1 moves the state to HOLD. cnt is not incremented past NSAMP-1.
  - Without an accept, all registers hold.
- State HOLD:
  - in_ready=0 and out_valid=1.
  - out_sum={acc_hi,acc_lo} and out_ovf=ovf, both driven straight from the registers.
  - in_data and in_valid are ignored.
  - When out_ready=1, acc_lo, acc_hi, ovf and cnt are cleared to 0 and the state moves to ACC.
  - When out_ready=0, all registers hold and the outputs stay stable.
- NSAMP=1: every accepted sample moves the block straight to HOLD.
- Arithmetic: out_sum is the true sum modulo 2^(6+HW). out_ovf=1 exactly when the true sum ≥ 2^(6+HW).

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=ACC.
  - acc_lo=0, acc_hi=0, ovf=0, cnt=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
  - Reset applied mid-frame or in HOLD discards the partial or pending frame with no output.
- Throughput: one sample per cycle in ACC.
- Latency: out_valid rises in the cycle after the edge that accepts the final sample.
- Frame period: the minimum is NSAMP+1 cycles, because HOLD lasts at least one cycle. in_ready returns to 1 the cycle after the out_ready handshake.
- No combinational path from in_valid or out_ready to in_ready or out_valid. Both ready/valid outputs are decoded from state only.
- The adder path (acc_lo → S/cout → acc_lo/acc_hi) must close in one clock period. The carry-counter increment follows cout in the same cycle.
- In HOLD, out_sum and out_ovf must not change until the handshake completes.

## Test plan
- Default parameters; reset, then 8 samples of 1 with in_valid held high → out_valid on the 9th cycle, out_sum=0x008, out_ovf=0, in_ready=0 during HOLD.
- 8 samples of 63 → out_sum=504 (0x1F8), out_ovf=0. The carry counter must read 7.
- HW=2 with 8 samples of 63 → out_sum=248 (504−256), out_ovf=1. The next frame of 8 samples of 0 → out_sum=0, out_ovf=0, confirming the clear.
- Gaps and backpressure: samples 10,20,30,40,1,2,3,4 with in_valid low for random cycles between them; out_ready held low for 5 cycles in HOLD → out_sum=110 stable for all 5 cycles; in_data toggling during HOLD has no effect.
- NSAMP=1: samples 33 and then 45 with out_ready=1 → two frames, out_sum=33 and then 45, with out_valid high for one cycle each.
- Reset pulse after the 4th sample of a frame → all outputs return to their reset values; the following full frame of 8 samples of 5 → out_sum=40.

Source files
------------

// File: rtl/adder_accum_if.sv
// Sample and frame handshake bundle for adder_accum.
// The master side feeds samples and consumes frames; the slave side is the accumulator.
interface adder_accum_if #(
  parameter int HW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_data;
  logic            out_valid;
  logic            out_ready;
  logic [5+HW:0]   out_sum;
  logic            out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/adder_accum.sv
// Frame accumulator: sums NSAMP 6-bit samples through a 6-bit prefix adder,
// extends the result with a carry counter and presents the frame on a handshake.
module adder (
  input  logic [5:0] X,
  input  logic [5:0] Y,
  output logic [5:0] S,
  output logic       cout
);
  logic [3:0][5:0] g_s;
  logic [3:0][5:0] p_s;

  assign g_s[0] = X & Y;
  assign p_s[0] = X ^ Y;

  // Kogge-Stone prefix tree: spans of 1, 2 and 4 bits
  for (genvar l = 0; l < 3; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < 6; i++) begin : g_bit
      if (i >= D) begin : g_comb
        assign g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][i-D]);
        assign p_s[l+1][i] = p_s[l][i] & p_s[l][i-D];
      end else begin : g_pass
        assign g_s[l+1][i] = g_s[l][i];
        assign p_s[l+1][i] = p_s[l][i];
      end
    end
  end

  assign S    = p_s[0] ^ {g_s[3][4:0], 1'b0};
  assign cout = g_s[3][5];
endmodule

module adder_accum #(
  parameter int NSAMP = 8,
  parameter int HW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_accum_if.slave  acc_if
);
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(NSAMP - 1);

  state_t          state_q, state_d;
  logic [5:0]      acc_lo_q, acc_lo_d;
  logic [HW-1:0]   acc_hi_q, acc_hi_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [5:0]      sum_s;
  logic            cout_s;

  adder u_adder (
    .X    (acc_lo_q),
    .Y    (acc_if.in_data),
    .S    (sum_s),
    .cout (cout_s)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACC;
      acc_lo_q <= 6'd0;
      acc_hi_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: accumulate in ACC, wait for the consumer in HOLD
  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      ACC: begin
        if (acc_if.in_valid) begin
          acc_lo_d = sum_s;
          if (cout_s) begin
            acc_hi_d = acc_hi_q + HW'(1);
            if (&acc_hi_q) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
          end else begin
            acc_hi_d = acc_hi_q;
          end
          // Final sample keeps cnt at NSAMP-1; the clear in HOLD resets it
          if (cnt_q == LAST_CNT) begin
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = ACC;
        end
      end
      HOLD: begin
        if (acc_if.out_ready) begin
          state_d  = ACC;
          acc_lo_d = 6'd0;
          acc_hi_d = '0;
          ovf_d    = 1'b0;
          cnt_d    = 8'd0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  assign acc_if.in_ready  = (state_q == ACC);
  assign acc_if.out_valid = (state_q == HOLD);
  assign acc_if.out_sum   = {acc_hi_q, acc_lo_q};
  assign acc_if.out_ovf   = ovf_q;
endmodule

// File: tb/tb_adder_accum.sv
// Randomised bench for adder_accum: three instances (default, HW=2, NSAMP=1)
// share one stimulus path and are checked against plain-arithmetic frame sums.
module tb_adder_accum;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        drv_valid;
  logic [5:0]  drv_data;
  logic        drv_ready;
  int          sel;
  int          total;
  int          bad;
  int          smp_q[$];

  logic        obs_ready;
  logic        obs_valid;
  logic [31:0] obs_sum;
  logic        obs_ovf;

  always #5 clk = ~clk;

  adder_accum_if #(.HW(4)) if_a ();
  adder_accum_if #(.HW(2)) if_b ();
  adder_accum_if #(.HW(4)) if_c ();

  adder_accum #(.NSAMP(8), .HW(4)) dut_a (.clk(clk), .rst_n(rst_n), .acc_if(if_a.slave));
  adder_accum #(.NSAMP(8), .HW(2)) dut_b (.clk(clk), .rst_n(rst_n), .acc_if(if_b.slave));
  adder_accum #(.NSAMP(1), .HW(4)) dut_c (.clk(clk), .rst_n(rst_n), .acc_if(if_c.slave));

  assign if_a.in_valid  = drv_valid && (sel == 0);
  assign if_b.in_valid  = drv_valid && (sel == 1);
  assign if_c.in_valid  = drv_valid && (sel == 2);
  assign if_a.out_ready = drv_ready && (sel == 0);
  assign if_b.out_ready = drv_ready && (sel == 1);
  assign if_c.out_ready = drv_ready && (sel == 2);
  assign if_a.in_data   = drv_data;
  assign if_b.in_data   = drv_data;
  assign if_c.in_data   = drv_data;

  always_comb begin
    obs_ready = if_c.in_ready;
    obs_valid = if_c.out_valid;
    obs_sum   = 32'(if_c.out_sum);
    obs_ovf   = if_c.out_ovf;
    if (sel == 0) begin
      obs_ready = if_a.in_ready;
      obs_valid = if_a.out_valid;
      obs_sum   = 32'(if_a.out_sum);
      obs_ovf   = if_a.out_ovf;
    end else if (sel == 1) begin
      obs_ready = if_b.in_ready;
      obs_valid = if_b.out_valid;
      obs_sum   = 32'(if_b.out_sum);
      obs_ovf   = if_b.out_ovf;
    end
  end

  function automatic int width_of(input int s);
    return (s == 1) ? 8 : 10;
  endfunction

  function automatic int nsamp_of(input int s);
    return (s == 2) ? 1 : 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s sel=%0d got=%0d want=%0d", tag, sel, got, exp);
    end
  endtask

  task automatic push_n(input int n, input int v);
    for (int k = 0; k < n; k++) smp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed one frame from smp_q, then hold it for hold_n cycles before draining.
  task automatic run_frame(input int gap_max, input int hold_n);
    int      n;
    int      gap;
    longint  true_sum;
    longint  modulus;
    logic [31:0] exp_sum;
    n        = nsamp_of(sel);
    true_sum = 0;
    modulus  = longint'(1) << width_of(sel);
    for (int k = 0; k < n; k++) begin
      int v;
      v = smp_q.pop_front();
      true_sum += v;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < gap; j++) begin
        drv_valid = 1'b0;
        drv_data  = 6'($urandom);
        tick();
        check("gap_rdy", 32'(obs_ready), 32'd1);
      end
      drv_valid = 1'b1;
      drv_data  = 6'(v);
      tick();
      drv_valid = 1'b0;
      if (k < n - 1) check("mid_vld", 32'(obs_valid), 32'd0);
    end
    exp_sum = 32'(true_sum % modulus);
    check("frm_vld", 32'(obs_valid), 32'd1);
    check("frm_rdy", 32'(obs_ready), 32'd0);
    check("frm_sum", obs_sum, exp_sum);
    check("frm_ovf", 32'(obs_ovf), 32'(true_sum >= modulus));
    drv_ready = 1'b0;
    for (int j = 0; j < hold_n; j++) begin
      drv_valid = 1'($urandom);
      drv_data  = 6'($urandom);
      tick();
      check("hold_sum", obs_sum, exp_sum);
      check("hold_vld", 32'(obs_valid), 32'd1);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    check("clr_vld", 32'(obs_valid), 32'd0);
    check("clr_rdy", 32'(obs_ready), 32'd1);
  endtask

  task automatic check_reset_state();
    check("rst_rdy", 32'(obs_ready), 32'd1);
    check("rst_vld", 32'(obs_valid), 32'd0);
    check("rst_sum", obs_sum, 32'd0);
    check("rst_ovf", 32'(obs_ovf), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    sel       = 0;
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    drv_data  = 6'd0;
    drv_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_reset_state();
    end

    sel = 0;
    push_n(8, 1);
    run_frame(0, 0);
    push_n(8, 63);
    run_frame(0, 1);
    foreach (smp_q[k]) smp_q.delete(k);
    smp_q = '{10, 20, 30, 40, 1, 2, 3, 4};
    run_frame(3, 5);

    sel = 1;
    #1;
    push_n(8, 63);
    run_frame(0, 0);
    push_n(8, 0);
    run_frame(1, 2);

    sel = 2;
    #1;
    smp_q.push_back(33);
    run_frame(0, 0);
    smp_q.push_back(45);
    run_frame(0, 0);

    // Reset in the middle of a frame discards the partial sum
    sel = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      drv_valid = 1'b1;
      drv_data  = 6'd9;
      tick();
    end
    drv_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state();
    push_n(8, 5);
    run_frame(0, 0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      for (int f = 0; f < 5; f++) begin
        for (int k = 0; k < nsamp_of(s); k++) smp_q.push_back(int'($urandom_range(63, 0)));
        run_frame(2, int'($urandom_range(3, 0)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
